// File: rtl/ddr4_init_pkg.sv
// rtl/ddr4_init_pkg.sv - shared types and pin encodings for the DDR4 init sequencer
package ddr4_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_CKE_WAIT,
    ST_XPR_WAIT,
    ST_MRS_ISSUE,
    ST_MRS_WAIT,
    ST_ZQ_ISSUE,
    ST_ZQ_WAIT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic cs_n;
    logic act_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } cmd_pins_t;

  localparam cmd_pins_t CMD_DES = cmd_pins_t'(5'b11111);
  localparam cmd_pins_t CMD_MRS = cmd_pins_t'(5'b01000);
  localparam cmd_pins_t CMD_ZQCL = cmd_pins_t'(5'b01110);

  localparam int ZQ_LONG_BIT = 10;

  // Entry 0 is issued first: MR3, MR6, MR5, MR4, MR2, MR1, MR0
  localparam logic [6:0][2:0] MR_ORDER = {3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd3};

  function automatic int max_of6(input int a, input int b, input int c,
                                 input int d, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return m;
  endfunction

endpackage

// File: rtl/ddr4_wait_timer.sv
// rtl/ddr4_wait_timer.sv - loadable down-counter that flags expiry at zero
module ddr4_wait_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ddr4_init_seq.sv
// rtl/ddr4_init_seq.sv - DDR4 reset, CKE, mode-register and ZQCL power-up sequencer
module ddr4_init_seq
  import ddr4_init_pkg::*;
#(
  parameter int          T_RESET  = 200,
  parameter int          T_STAB   = 500,
  parameter int          T_XPR    = 10,
  parameter int          T_MRD    = 8,
  parameter int          T_MOD    = 24,
  parameter int          T_ZQINIT = 1024,
  parameter logic [13:0] MR0_VAL  = 14'h0000,
  parameter logic [13:0] MR1_VAL  = 14'h0000,
  parameter logic [13:0] MR2_VAL  = 14'h0000,
  parameter logic [13:0] MR3_VAL  = 14'h0000,
  parameter logic [13:0] MR4_VAL  = 14'h0000,
  parameter logic [13:0] MR5_VAL  = 14'h0000,
  parameter logic [13:0] MR6_VAL  = 14'h0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        reset_n_o,
  output logic        cke_o,
  output logic        cs_n_o,
  output logic        act_n_o,
  output logic        ras_n_a16_o,
  output logic        cas_n_a15_o,
  output logic        we_n_a14_o,
  output logic        bg_o,
  output logic [1:0]  ba_o,
  output logic [13:0] addr_o,
  output logic        addr_17_o,
  output logic        odt_o
);

  localparam int CW = $clog2(max_of6(T_RESET, T_STAB, T_XPR, T_MRD, T_MOD, T_ZQINIT) + 1);

  state_e      state_q;
  cmd_pins_t   cmd_q;
  logic [2:0]  mr_idx_q;
  logic        busy_q, done_q, reset_n_q, cke_q, bg_q;
  logic [1:0]  ba_q;
  logic [13:0] addr_q;

  logic          tmr_load, tmr_expired;
  logic [CW-1:0] tmr_val;
  logic [2:0]    next_idx, next_mr;

  function automatic logic [13:0] mr_val(input logic [2:0] n);
    case (n)
      3'd0:    return MR0_VAL;
      3'd1:    return MR1_VAL;
      3'd2:    return MR2_VAL;
      3'd3:    return MR3_VAL;
      3'd4:    return MR4_VAL;
      3'd5:    return MR5_VAL;
      3'd6:    return MR6_VAL;
      default: return 14'h0000;
    endcase
  endfunction

  // The timer reloads on every state-advancing edge with the wait that follows it
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    next_idx = (state_q == ST_XPR_WAIT) ? 3'd0 : mr_idx_q + 3'd1;
    next_mr  = MR_ORDER[next_idx];
    case (state_q)
      ST_IDLE, ST_DONE: begin
        tmr_load = start_i;
        tmr_val  = CW'(T_RESET - 1);
      end
      ST_RST_LOW: begin
        tmr_load = tmr_expired;
        tmr_val  = CW'(T_STAB - 1);
      end
      ST_CKE_WAIT: begin
        tmr_load = tmr_expired;
        tmr_val  = CW'(T_XPR - 1);
      end
      ST_XPR_WAIT: begin
        tmr_load = tmr_expired;
        tmr_val  = CW'(T_MRD - 1);
      end
      ST_MRS_ISSUE, ST_MRS_WAIT: begin
        tmr_load = tmr_expired;
        if (mr_idx_q == 3'd6)      tmr_val = CW'(T_ZQINIT - 1);
        else if (next_mr == 3'd0)  tmr_val = CW'(T_MOD - 1);
        else                       tmr_val = CW'(T_MRD - 1);
      end
      default: ;
    endcase
  end

  ddr4_wait_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_DES;
      mr_idx_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      bg_q      <= 1'b0;
      ba_q      <= '0;
      addr_q    <= '0;
    end else begin
      cmd_q  <= CMD_DES;
      bg_q   <= 1'b0;
      ba_q   <= '0;
      addr_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE: if (start_i) begin
          state_q   <= ST_RST_LOW;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          reset_n_q <= 1'b0;
          cke_q     <= 1'b0;
          mr_idx_q  <= '0;
        end
        ST_RST_LOW: if (tmr_expired) begin
          state_q   <= ST_CKE_WAIT;
          reset_n_q <= 1'b1;
        end
        ST_CKE_WAIT: if (tmr_expired) begin
          state_q <= ST_XPR_WAIT;
          cke_q   <= 1'b1;
        end
        ST_XPR_WAIT, ST_MRS_ISSUE, ST_MRS_WAIT: begin
          if (tmr_expired && state_q != ST_XPR_WAIT && mr_idx_q == 3'd6) begin
            state_q             <= ST_ZQ_ISSUE;
            cmd_q               <= CMD_ZQCL;
            addr_q[ZQ_LONG_BIT] <= 1'b1;
          end else if (tmr_expired) begin
            state_q  <= ST_MRS_ISSUE;
            cmd_q    <= CMD_MRS;
            mr_idx_q <= next_idx;
            bg_q     <= next_mr[2];
            ba_q     <= next_mr[1:0];
            addr_q   <= mr_val(next_mr);
          end else if (state_q != ST_XPR_WAIT) begin
            state_q <= ST_MRS_WAIT;
          end
        end
        ST_ZQ_ISSUE, ST_ZQ_WAIT: begin
          if (tmr_expired) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ZQ_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign reset_n_o   = reset_n_q;
  assign cke_o       = cke_q;
  assign cs_n_o      = cmd_q.cs_n;
  assign act_n_o     = cmd_q.act_n;
  assign ras_n_a16_o = cmd_q.ras_n;
  assign cas_n_a15_o = cmd_q.cas_n;
  assign we_n_a14_o  = cmd_q.we_n;
  assign bg_o        = bg_q;
  assign ba_o        = ba_q;
  assign addr_o      = addr_q;
  assign addr_17_o   = 1'b0;
  assign odt_o       = 1'b0;

endmodule

// File: tb/tb_ddr4_init_seq.sv
// tb/tb_ddr4_init_seq.sv - directed self-checking bench for ddr4_init_seq
module tb_ddr4_init_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i;
  logic        busy_o, done_o, reset_n_o, cke_o, cs_n_o, act_n_o;
  logic        ras_n_a16_o, cas_n_a15_o, we_n_a14_o, bg_o, addr_17_o, odt_o;
  logic [1:0]  ba_o;
  logic [13:0] addr_o;

  int checks = 0;
  int passed = 0;
  logic prev_cke = 1'b0;

  always #5 clk = ~clk;

  ddr4_init_seq #(
    .T_RESET(4), .T_STAB(5), .T_XPR(3), .T_MRD(2), .T_MOD(3), .T_ZQINIT(6),
    .MR0_VAL(14'h0100), .MR1_VAL(14'h0101), .MR2_VAL(14'h0102), .MR3_VAL(14'h0103),
    .MR4_VAL(14'h0104), .MR5_VAL(14'h0105), .MR6_VAL(14'h0106)
  ) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .reset_n_o(reset_n_o), .cke_o(cke_o), .cs_n_o(cs_n_o), .act_n_o(act_n_o),
    .ras_n_a16_o(ras_n_a16_o), .cas_n_a15_o(cas_n_a15_o), .we_n_a14_o(we_n_a14_o),
    .bg_o(bg_o), .ba_o(ba_o), .addr_o(addr_o), .addr_17_o(addr_17_o), .odt_o(odt_o)
  );

  // Bus hygiene on every cycle
  always @(negedge clk) begin
    checks++;
    if (odt_o !== 1'b0 || addr_17_o !== 1'b0)
      $display("FAIL hygiene_odt_a17 odt=%b a17=%b required 0/0", odt_o, addr_17_o);
    else passed++;
    checks++;
    if (prev_cke === 1'b1 && cke_o === 1'b0 && reset_n_o === 1'b1)
      $display("FAIL hygiene_cke_fall cke=%b reset_n=%b required no cke fall", cke_o, reset_n_o);
    else passed++;
    prev_cke = cke_o;
  end

  // Must be entered at a negedge; n counts edges, n=1 samples the start pulse
  task automatic run_seq(input string name, input int last_n, input int p1, input int p2);
    int mr_order[7] = '{3, 6, 5, 4, 2, 1, 0};
    logic [25:0] obs, exp_v;
    logic [4:0]  e_cmd;
    logic [13:0] e_addr;
    logic [2:0]  m;
    for (int n = 1; n <= last_n; n++) begin
      start_i = (n == 1) || (n == p1) || (n == p2);
      @(posedge clk);
      @(negedge clk);
      e_cmd  = 5'b11111;
      e_addr = 14'h0;
      m      = 3'd0;
      if (n >= 13 && n <= 25 && ((n - 13) % 2 == 0)) begin
        m      = 3'(mr_order[(n - 13) / 2]);
        e_cmd  = 5'b01000;
        e_addr = 14'h0100 + 14'(m);
      end else if (n == 28) begin
        e_cmd  = 5'b01110;
        e_addr = 14'h0400;
      end
      exp_v = {(n < 34), (n >= 34), (n >= 5), (n >= 10), e_cmd, m[2], m[1:0], e_addr};
      obs   = {busy_o, done_o, reset_n_o, cke_o, cs_n_o, act_n_o, ras_n_a16_o,
               cas_n_a15_o, we_n_a14_o, bg_o, ba_o, addr_o};
      checks++;
      if (obs !== exp_v)
        $display("FAIL %s edge=%0d got=%h required=%h", name, n, obs, exp_v);
      else passed++;
    end
    start_i = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, reset_n_o, cke_o, cs_n_o} !== 5'b00001)
        $display("FAIL %s cycle=%0d got=%b required=00001", name, i,
                 {busy_o, done_o, reset_n_o, cke_o, cs_n_o});
      else passed++;
    end
  endtask

  task automatic test_reset;
    logic [30:0] obs;
    rstn    = 1'b1;
    start_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    obs = {busy_o, done_o, reset_n_o, cke_o, cs_n_o, act_n_o, ras_n_a16_o, cas_n_a15_o,
           we_n_a14_o, bg_o, ba_o, addr_o, addr_17_o, odt_o, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== {4'b0000, 5'b11111, 1'b0, 2'b00, 14'h0, 5'b00000})
      $display("FAIL reset_values got=%h required=%h", obs,
               {4'b0000, 5'b11111, 1'b0, 2'b00, 14'h0, 5'b00000});
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    check_idle("reset_no_start", 6);
  endtask

  task automatic test_nominal;
    run_seq("nominal", 36, 0, 0);
  endtask

  task automatic test_reinit_from_done;
    run_seq("reinit", 36, 0, 0);
  endtask

  task automatic test_start_while_busy;
    run_seq("start_busy", 36, 3, 20);
  endtask

  task automatic test_mid_reset;
    run_seq("mid_pre", 17, 0, 0);
    rstn = 1'b0;
    #1;
    checks++;
    if ({reset_n_o, cke_o, cs_n_o, busy_o, done_o} !== 5'b00100)
      $display("FAIL mid_reset_async got=%b required=00100",
               {reset_n_o, cke_o, cs_n_o, busy_o, done_o});
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    check_idle("mid_reset_idle", 8);
    run_seq("mid_restart", 36, 0, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reinit_from_done();
    test_start_while_busy();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ddr4_init_seq.md
# ddr4_init_seq

DDR4 power-up and initialisation sequencer that drives the command/control pins of the DDR4 device wrapper directly upstream. On a start request it performs the JEDEC DDR4 reset, clock-enable and mode-register sequence:
- RESET_n pulse
- CKE enable
- MR3, MR6, MR5, MR4, MR2, MR1, MR0 writes
- ZQCL calibration

All waits are programmable cycle counts. It then flags completion so the memory controller can take over the bus.

## Interface
Parameters:
- T_RESET, 200: cycles reset_n_o held low after start (≥1)
- T_STAB, 500: cycles from reset_n_o rise to cke_o rise (≥1)
- T_XPR, 10: cycles from cke_o rise to first MRS (≥1)
- T_MRD, 8: cycles between consecutive MRS commands (≥1)
- T_MOD, 24: cycles from MR0 to ZQCL (≥1)
- T_ZQINIT, 1024: cycles from ZQCL to done (≥1)
- MR0_VAL … MR6_VAL, 14'h0000: 14-bit address-bus payload for each mode register

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  request init sequence; sampled only in IDLE or DONE
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence complete; sticky until next start
- reset_n_o  out  1  DRAM RESET_n
- cke_o  out  1  DRAM CKE
- cs_n_o  out  1  chip select, active low
- act_n_o  out  1  ACT_n
- ras_n_a16_o, cas_n_a15_o, we_n_a14_o  out  1 each  command pins
- bg_o  out  1  bank group
- ba_o  out  2  bank address
- addr_o  out  14  address bus
- addr_17_o  out  1  always 0
- odt_o  out  1  always 0

## Operation
- FSM states: IDLE → RST_LOW → CKE_WAIT → XPR_WAIT → MRS_ISSUE ⇄ MRS_WAIT → ZQ_ISSUE → ZQ_WAIT → DONE.
- IDLE/DONE:
  - start_i=1 moves the FSM to RST_LOW and forces reset_n_o=0, cke_o=0, done_o=0.
  - start_i=1 in DONE re-runs the full sequence.
- RST_LOW: hold for T_RESET cycles, then set reset_n_o=1 and go to CKE_WAIT.
- CKE_WAIT: hold for T_STAB cycles, then set cke_o=1 and go to XPR_WAIT.
- XPR_WAIT: hold for T_XPR cycles, then go to MRS_ISSUE.
- MRS_ISSUE: one-cycle MRS command.
  - Pins: cs_n=0, act_n=1, ras=0, cas=0, we=0.
  - bg_o = MR index bit 2; ba_o = index bits 1:0; addr_o = MRx_VAL.
  - Index order: 3, 6, 5, 4, 2, 1, 0.
- MRS_WAIT: hold for T_MRD cycles after MR0–MR6 except MR0; after MR0, hold for T_MOD.
- ZQ_ISSUE: one-cycle ZQCL. Pins: cs_n=0, act_n=1, ras=1, cas=1, we=0, addr_o[10]=1, all other addr/bg/ba bits 0.
- ZQ_WAIT: hold for T_ZQINIT cycles, then go to DONE with done_o=1 and busy_o=0.
- All non-issue cycles are DES: cs_n=1, act_n=ras=cas=we=1, bg=ba=addr=0.
- start_i is ignored while busy_o=1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values:
  - reset_n_o=0, cke_o=0, cs_n_o=1, act_n_o=1, ras/cas/we=1
  - bg_o=0, ba_o=0, addr_o=0, addr_17_o=0, odt_o=0
  - busy_o=0, done_o=0, FSM=IDLE
- rstn assertion mid-sequence: every output returns to its reset value asynchronously (DRAM back in reset). Sequence restarts only on a new start_i.
- Absolute cycle positions, with start_i sampled at edge 0:
  - busy_o=1 from edge 1
  - reset_n_o rises at edge 1+T_RESET
  - cke_o rises T_STAB cycles after reset_n_o rises
  - MR3 issues T_XPR cycles after cke_o rises
  - Each following MRS issues T_MRD cycles after the previous one
  - ZQCL issues T_MOD cycles after MR0
  - done_o rises T_ZQINIT cycles after ZQCL
- Exactly 8 cycles with cs_n_o=0 per sequence.
- Counter width is $clog2(max(T_*)+1). Counter loads (T−1) on state entry; the state exits when the counter reads 0.

## Structure
- Package ddr4_init_pkg holds:
  - FSM state enum
  - MRS/ZQCL/DES pin-encoding constants
  - MR issue-order constant array {3,6,5,4,2,1,0}
- One sub-module, ddr4_wait_timer: load/decrement counter with an expire flag, parameterised width. The FSM uses one instance.

## Test plan
Use small parameters: T_RESET=4, T_STAB=5, T_XPR=3, T_MRD=2, T_MOD=3, T_ZQINIT=6, MRx_VAL=14'h0100+x.
- Nominal sequence: start pulse at edge 0 →
  - reset_n_o rises at edge 5, cke_o at edge 10
  - MRS at edges 13/15/17/19/21/23/25 carrying indices 3/6/5/4/2/1/0 and addr_o 0x103/0x106/0x105/0x104/0x102/0x101/0x100
  - ZQCL at edge 28 with addr_o=0x400
  - done_o=1, busy_o=0 at edge 34
- Reset state: rstn low → all outputs at listed reset values. No command issues without start_i.
- Start while busy: start_i pulsed at edges 3 and 20 → cycle timing identical to nominal.
- Mid-sequence reset: rstn low at edge 18 → reset_n_o=0, cke_o=0, cs_n_o=1 before next edge. After release, nothing issues until a new start; a new start then reproduces nominal timing.
- Re-init from DONE: start_i after done_o → done_o clears and reset_n_o drops at the next edge. Full nominal sequence repeats.
- Bus hygiene: check every cycle that cs_n_o=1 in all cycles except the 8 command cycles, that odt_o and addr_17_o are always 0, and that cke_o never falls while reset_n_o=1 except via rstn or restart.
